// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard and stall controller for the five-stage pipeline.
// Generates the PC/FD/DX latch write enables and the nop-injection flushes
// for FD, DX and XM.  Detects load-use hazards between D_IR and X_IR, flushes
// on taken control transfers, and holds the pipeline while the multi-cycle
// multiplier/divider runs.  It also keeps a saturating count of stall cycles.
//
// Ports
//   clock            pipeline clock, rising edge
//   reset            asynchronous, active-low
//   D_IR, X_IR       decode- and execute-stage instructions
//   X_branch_taken   execute-stage control transfer is taken
//   md_ready         multdiv result valid (one-cycle pulse)
//   PC_en, FD_en, DX_en            latch write enables
//   FD_flush, DX_flush, XM_flush   load a nop into that latch this edge
//   md_start         one-cycle multdiv start pulse
//   md_timeout       one-cycle pulse when the multdiv wait expires
//   stall_cycles     saturating count of cycles with PC_en=0
//
// state   | meaning
// --------+--------------------------------------------------------------
// RUN     | normal issue; branch flush, mul/div launch, load-use bubble
// MD_WAIT | pipeline frozen until md_ready or the wait counter expires

module pipeline_ctrl #(
   parameter int MD_TIMEOUT = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] D_IR,
   input  logic [31:0] X_IR,
   input  logic        X_branch_taken,
   input  logic        md_ready,
   output logic        PC_en,
   output logic        FD_en,
   output logic        DX_en,
   output logic        FD_flush,
   output logic        DX_flush,
   output logic        XM_flush,
   output logic        md_start,
   output logic        md_timeout,
   output logic [15:0] stall_cycles
);

   localparam logic [4:0] OP_R    = 5'b00000;
   localparam logic [4:0] OP_BNE  = 5'b00010;
   localparam logic [4:0] OP_JR   = 5'b00100;
   localparam logic [4:0] OP_ADDI = 5'b00101;
   localparam logic [4:0] OP_BLT  = 5'b00110;
   localparam logic [4:0] OP_SW   = 5'b00111;
   localparam logic [4:0] OP_LW   = 5'b01000;
   localparam logic [4:0] OP_BEX  = 5'b10110;
   localparam logic [4:0] ALU_MUL = 5'b00110;
   localparam logic [4:0] ALU_DIV = 5'b00111;
   localparam logic [5:0] WAIT_LAST = 6'(MD_TIMEOUT - 1);

   typedef enum logic {RUN, MD_WAIT} state_t;

   state_t     state, state_next;
   logic [5:0] wait_cnt, wait_cnt_next;

   logic [4:0] d_op, d_rd, d_rs, d_rt;
   logic [4:0] x_op, x_rd;
   logic       x_is_md;
   logic       load_use;

   // Raw decoded controls; the ports gate these with reset.
   logic pc_en_d, fd_en_d, dx_en_d;
   logic fd_flush_d, dx_flush_d, xm_flush_d;
   logic md_start_d, md_timeout_d;

   assign d_op = D_IR[31:27];
   assign d_rd = D_IR[26:22];
   assign d_rs = D_IR[21:17];
   assign d_rt = D_IR[16:12];
   assign x_op = X_IR[31:27];
   assign x_rd = X_IR[26:22];

   assign x_is_md = (x_op == OP_R) &&
                    ((X_IR[6:2] == ALU_MUL) || (X_IR[6:2] == ALU_DIV));

   // x_rd is nonzero, so an r0 source can never match.
   always_comb begin
      load_use = 1'b0;
      if (x_op == OP_LW && x_rd != 5'd0) begin
         unique case (d_op)
            OP_R:                 load_use = (d_rs == x_rd) || (d_rt == x_rd);
            OP_ADDI, OP_LW:       load_use = (d_rs == x_rd);
            OP_SW, OP_BNE, OP_BLT: load_use = (d_rd == x_rd) || (d_rs == x_rd);
            OP_JR:                load_use = (d_rd == x_rd);
            OP_BEX:               load_use = (x_rd == 5'd30);
            default:              load_use = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= RUN;
         wait_cnt <= 6'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   always_comb begin
      pc_en_d       = 1'b1;
      fd_en_d       = 1'b1;
      dx_en_d       = 1'b1;
      fd_flush_d    = 1'b0;
      dx_flush_d    = 1'b0;
      xm_flush_d    = 1'b0;
      md_start_d    = 1'b0;
      md_timeout_d  = 1'b0;
      state_next    = state;
      wait_cnt_next = wait_cnt;
      unique case (state)
         RUN: begin
            if (X_branch_taken) begin
               fd_flush_d = 1'b1;
               dx_flush_d = 1'b1;
            end else if (x_is_md) begin
               md_start_d    = 1'b1;
               pc_en_d       = 1'b0;
               fd_en_d       = 1'b0;
               dx_en_d       = 1'b0;
               xm_flush_d    = 1'b1;
               state_next    = MD_WAIT;
               wait_cnt_next = 6'd0;
            end else if (load_use) begin
               pc_en_d    = 1'b0;
               fd_en_d    = 1'b0;
               dx_flush_d = 1'b1;
            end
         end
         MD_WAIT: begin
            if (md_ready) begin
               state_next = RUN;
            end else if (wait_cnt == WAIT_LAST) begin
               md_timeout_d = 1'b1;
               state_next   = RUN;
            end else begin
               pc_en_d       = 1'b0;
               fd_en_d       = 1'b0;
               dx_en_d       = 1'b0;
               xm_flush_d    = 1'b1;
               wait_cnt_next = wait_cnt + 6'd1;
            end
         end
         default: state_next = RUN;
      endcase
   end

   assign PC_en      = pc_en_d | ~reset;
   assign FD_en      = fd_en_d | ~reset;
   assign DX_en      = dx_en_d | ~reset;
   assign FD_flush   = fd_flush_d & reset;
   assign DX_flush   = dx_flush_d & reset;
   assign XM_flush   = xm_flush_d & reset;
   assign md_start   = md_start_d & reset;
   assign md_timeout = md_timeout_d & reset;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stall_cycles <= 16'd0;
      end else if (!pc_en_d && stall_cycles != 16'hFFFF) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] D_IR, X_IR;
   logic        X_branch_taken, md_ready;
   logic        PC_en, FD_en, DX_en, FD_flush, DX_flush, XM_flush;
   logic        md_start, md_timeout;
   logic [15:0] stall_cycles;

   pipeline_ctrl #(.MD_TIMEOUT(64)) dut (
      .clock(clock), .reset(reset), .D_IR(D_IR), .X_IR(X_IR),
      .X_branch_taken(X_branch_taken), .md_ready(md_ready),
      .PC_en(PC_en), .FD_en(FD_en), .DX_en(DX_en),
      .FD_flush(FD_flush), .DX_flush(DX_flush), .XM_flush(XM_flush),
      .md_start(md_start), .md_timeout(md_timeout), .stall_cycles(stall_cycles)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc(input int op, input int rd, input int rs,
                                       input int rt, input int aluop);
      enc = {op[4:0], rd[4:0], rs[4:0], rt[4:0], 5'd0, aluop[4:0], 2'b00};
   endfunction

   localparam logic [31:0] NOP     = 32'd0;
   localparam logic [31:0] MUL     = enc(0, 3, 1, 2, 6);
   localparam logic [31:0] DIV     = enc(0, 3, 1, 2, 7);
   localparam logic [31:0] LW0     = enc(8, 0, 2, 0, 0);
   localparam logic [31:0] LW3     = enc(8, 3, 2, 0, 0);
   localparam logic [31:0] LW4     = enc(8, 4, 2, 0, 0);
   localparam logic [31:0] LW5     = enc(8, 5, 2, 0, 0);
   localparam logic [31:0] LW7     = enc(8, 7, 2, 0, 0);
   localparam logic [31:0] LW30    = enc(8, 30, 2, 0, 0);
   localparam logic [31:0] ADD_R5  = enc(0, 1, 5, 2, 0);
   localparam logic [31:0] ADD_R0  = enc(0, 1, 0, 0, 0);
   localparam logic [31:0] ADDI_R6 = enc(5, 1, 6, 0, 0);
   localparam logic [31:0] BNE_R5  = enc(2, 5, 9, 0, 0);
   localparam logic [31:0] BEX     = enc(22, 0, 0, 0, 0);
   localparam logic [31:0] JR7     = enc(4, 7, 0, 0, 0);
   localparam logic [31:0] SW3     = enc(7, 3, 1, 0, 0);
   localparam logic [31:0] J4      = enc(1, 4, 0, 0, 0);

   // ---------------- reference model ----------------
   function automatic bit reads_reg(input logic [31:0] d, input logic [4:0] r);
      logic [4:0] op, rd, rs, rt;
      op = d[31:27]; rd = d[26:22]; rs = d[21:17]; rt = d[16:12];
      if (r == 5'd0) return 1'b0;
      case (op)
         5'd0:        return (rs == r) || (rt == r);
         5'd5, 5'd8:  return rs == r;
         5'd2, 5'd6, 5'd7: return (rd == r) || (rs == r);
         5'd4:        return rd == r;
         5'd22:       return r == 5'd30;
         default:     return 1'b0;
      endcase
   endfunction

   function automatic bit is_md(input logic [31:0] x);
      return (x[31:27] == 5'd0) && (x[6:2] == 5'd6 || x[6:2] == 5'd7);
   endfunction

   function automatic bit hazard(input logic [31:0] d, input logic [31:0] x);
      return (x[31:27] == 5'd8) && reads_reg(d, x[26:22]);
   endfunction

   bit       m_busy = 0;      // multdiv launched and not yet released
   int       m_elapsed = 0;   // wait cycles already spent since launch
   int       m_stalls = 0;
   bit [7:0] e;               // {PC,FD,DX,FDf,DXf,XMf,start,timeout}
   bit [7:0] a;

   always @(negedge clock) begin
      if (!reset) begin
         m_busy = 0; m_elapsed = 0; m_stalls = 0;
         e = 8'b111_000_00;
      end else if (m_busy) begin
         if (md_ready)              e = 8'b111_000_00;
         else if (m_elapsed == 63)  e = 8'b111_000_01;
         else                       e = 8'b000_001_00;
      end else begin
         if (X_branch_taken)           e = 8'b111_110_00;
         else if (is_md(X_IR))         e = 8'b000_001_10;
         else if (hazard(D_IR, X_IR))  e = 8'b001_010_00;
         else                          e = 8'b111_000_00;
      end
      a = {PC_en, FD_en, DX_en, FD_flush, DX_flush, XM_flush, md_start, md_timeout};
      chk("ctrl_outputs", {24'd0, a}, {24'd0, e});
      chk("stall_count", {16'd0, stall_cycles},
          (m_stalls > 65535) ? 32'd65535 : 32'(m_stalls));
      if (reset) begin
         if (!e[7]) m_stalls++;
         if (!m_busy && e[1])           begin m_busy = 1; m_elapsed = 0; end
         else if (m_busy && e[7])       m_busy = 0;
         else if (m_busy)               m_elapsed++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc(input logic rst, input logic [31:0] d, input logic [31:0] x,
                      input logic br, input logic rdy);
      @(posedge clock);
      #1;
      reset = rst; D_IR = d; X_IR = x; X_branch_taken = br; md_ready = rdy;
      @(negedge clock);
   endtask

   initial begin
      reset = 1'b0; D_IR = NOP; X_IR = MUL; X_branch_taken = 1'b0; md_ready = 1'b0;

      cyc(0, NOP, MUL, 0, 0);
      chk("rst_pc_en", PC_en, 1);
      chk("rst_md_start", md_start, 0);
      chk("rst_stall", stall_cycles, 0);
      cyc(0, NOP, MUL, 0, 0);

      cyc(1, NOP, MUL, 0, 0);
      chk("md_first_start", md_start, 1);
      chk("md_first_pc", PC_en, 0);
      repeat (3) cyc(1, NOP, MUL, 0, 0);
      chk("md_wait_xm", XM_flush, 1);
      chk("md_wait_nostart", md_start, 0);
      cyc(1, NOP, MUL, 0, 1);
      chk("md_rel_xm", XM_flush, 0);
      chk("md_rel_pc", PC_en, 1);
      chk("md_rel_stall", stall_cycles, 4);
      cyc(1, NOP, NOP, 0, 0);
      chk("md_no_restart", md_start, 0);

      cyc(1, ADD_R5, LW5, 0, 0);
      chk("lu_pc", PC_en, 0);
      chk("lu_dxf", DX_flush, 1);
      chk("lu_dxen", DX_en, 1);
      cyc(1, ADD_R5, NOP, 0, 0);
      chk("lu_after_pc", PC_en, 1);
      chk("lu_after_stall", stall_cycles, 5);

      cyc(1, ADD_R0, LW0, 0, 0);
      chk("lu_r0_pc", PC_en, 1);
      cyc(1, ADDI_R6, LW5, 0, 0);
      chk("lu_nomatch_pc", PC_en, 1);

      cyc(1, BNE_R5, LW5, 1, 0);
      chk("br_fdf", FD_flush, 1);
      chk("br_dxf", DX_flush, 1);
      chk("br_pc", PC_en, 1);
      chk("br_stall", stall_cycles, 5);

      cyc(1, BEX, LW30, 0, 0);
      chk("lu_bex_pc", PC_en, 0);
      cyc(1, JR7, LW7, 0, 0);
      chk("lu_jr_pc", PC_en, 0);
      cyc(1, SW3, LW3, 0, 0);
      chk("lu_sw_pc", PC_en, 0);
      cyc(1, J4, LW4, 0, 0);
      chk("lu_j_pc", PC_en, 1);
      chk("lu_j_stall", stall_cycles, 8);

      cyc(1, NOP, MUL, 1, 0);
      chk("br_over_md_start", md_start, 0);
      chk("br_over_md_fdf", FD_flush, 1);
      cyc(1, NOP, NOP, 0, 1);
      chk("rdy_in_run_pc", PC_en, 1);

      cyc(1, NOP, DIV, 0, 0);
      chk("div_start", md_start, 1);
      repeat (63) cyc(1, NOP, DIV, 0, 0);
      chk("div_63_no_timeout", md_timeout, 0);
      cyc(1, NOP, DIV, 0, 0);
      chk("div_timeout", md_timeout, 1);
      chk("div_timeout_pc", PC_en, 1);
      chk("div_timeout_stall", stall_cycles, 72);
      cyc(1, NOP, NOP, 0, 0);
      chk("div_after_timeout", md_timeout, 0);
      chk("div_after_pc", PC_en, 1);

      cyc(1, NOP, MUL, 0, 0);
      repeat (3) cyc(1, NOP, MUL, 0, 0);
      cyc(0, NOP, MUL, 0, 0);
      chk("midwait_rst_stall", stall_cycles, 0);
      chk("midwait_rst_pc", PC_en, 1);
      chk("midwait_rst_start", md_start, 0);
      cyc(1, NOP, MUL, 0, 0);
      chk("midwait_redecode", md_start, 1);
      cyc(1, NOP, MUL, 0, 1);
      chk("midwait_release", PC_en, 1);
      cyc(1, NOP, NOP, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and stall controller for the five-stage pipeline. It sequences the FD, DX and XM pipeline latches and the PC register by generating their write enables and nop-injection flushes. It detects load-use hazards and taken control transfers, and it holds the pipeline while the multi-cycle multiplier/divider runs. It sits beside the latches, decodes D_IR and X_IR, and keeps a saturating stall-cycle counter for performance debug.

## Interface
- MD_TIMEOUT, 64: maximum cycles spent in MD_WAIT before a forced release.
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low.
- D_IR  in  32  instruction in the decode stage (FD latch output).
- X_IR  in  32  instruction in the execute stage (DX latch output).
- X_branch_taken  in  1  execute-stage control transfer is taken (bne/blt taken, j, jal, jr, bex taken).
- md_ready  in  1  multdiv result valid, one-cycle pulse.
- PC_en, FD_en, DX_en  out  1 each  latch write enables.
- FD_flush, DX_flush, XM_flush  out  1 each  load a nop (32'b0) into that latch this edge.
- md_start  out  1  one-cycle multdiv start pulse.
- md_timeout  out  1  one-cycle pulse when MD_TIMEOUT expires.
- stall_cycles  out  16  count of cycles with PC_en=0, saturating.

## Operation
- Instruction fields: opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
- Opcodes: R=00000, j=00001, bne=00010, jal=00011, jr=00100, addi=00101, blt=00110, sw=00111, lw=01000, setx=10101, bex=10110.
- mul/div is X_IR opcode 00000 with aluop 00110 or 00111.
- D sources:
  - R: rs, rt.
  - addi, lw: rs.
  - sw, bne, blt: rd and rs.
  - jr: rd.
  - bex: r30.
  - Others: none.
  - A source of r0 never hazards.
- Load-use hazard: X opcode is lw, X rd is nonzero, and X rd equals any D source.
- FSM states: RUN and MD_WAIT. A 6-bit wait counter is cleared on entry to MD_WAIT.
- RUN, evaluated in this priority order:
  1. X_branch_taken: FD_flush=1, DX_flush=1, all enables 1. This also overrides any load-use hazard in the same cycle.
  2. X is mul/div: md_start=1, PC_en=FD_en=DX_en=0, XM_flush=1. Next state MD_WAIT.
  3. Load-use hazard: PC_en=FD_en=0, DX_flush=1, DX_en=1.
  4. Otherwise: all enables 1, all flushes 0.
- MD_WAIT:
  - md_ready=0 and counter < MD_TIMEOUT-1: PC_en=FD_en=DX_en=0, XM_flush=1, counter increments. Load-use and branch inputs are ignored.
  - md_ready=1: all enables 1, flushes 0 so the result enters XM. Next state RUN.
  - Counter = MD_TIMEOUT-1 without md_ready: md_timeout=1, same outputs as md_ready=1. Next state RUN.
- md_start never re-fires for the same instruction, because DX_en=1 on release advances X_IR.
- stall_cycles increments on every rising edge where PC_en=0 and holds at 16'hFFFF.

## Timing
- While reset=0, outputs are forced to:
  - PC_en=FD_en=DX_en=1.
  - All flushes 0.
  - md_start=md_timeout=0.
  - stall_cycles=0, state RUN, counter 0.
- After reset deasserts, the first edge already uses decoded behaviour.
- Enables, flushes and md_start are combinational from state and inputs, with no added latency. State, counter and stall_cycles are registered.
- Load-use: a one-cycle bubble. At edge T, D is held and a nop enters DX. At T+1, the lw is in M, the hazard clears, and D advances.
- Mul/div occupies 1 + N cycles, where md_ready arrives N cycles after md_start (N ≥ 1). md_ready in RUN is ignored.
- Reset asserted mid-MD_WAIT: the state returns to RUN immediately and md_start stays 0 until re-decoded.

## Test plan
- Reset low with X_IR=mul → all enables 1, md_start=0, stall_cycles=0. Release → md_start=1 in the first cycle.
- X_IR=lw r5, D_IR=add r1,r5,r2 → one cycle with PC_en=FD_en=0, DX_flush=1; next cycle normal; stall_cycles=1.
- X_IR=lw r0 against D reading r0, and X_IR=lw r5 against D=addi r1,r6 → no stall.
- X_IR=lw r5, D=bne r5, with X_branch_taken=1 → FD_flush=DX_flush=1, PC_en=1, stall_cycles unchanged.
- X_IR=mul, md_ready after 4 cycles → md_start for 1 cycle, 4 stall cycles, release with XM_flush=0, stall_cycles=4, no re-start.
- X_IR=div, md_ready never arrives, MD_TIMEOUT=64 → md_timeout pulses in the 64th MD_WAIT cycle, then RUN.
- Reset asserted mid-wait → state RUN, stall_cycles=0.
